// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter
//
// Shares one 10110 overlapping-pattern detector among NUM_CH serial bit
// requesters. Each channel keeps its own detector state. A round-robin
// arbiter accepts one bit per cycle. The result for that bit is registered
// and tagged with the channel it came from.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         asynchronous active-high reset; clears all state
//   req_valid     per-channel bit offer
//   req_bit       per-channel serial data bit
//   req_ready     one-hot grant (combinational); forced low while reset is high
//   ctx_clear     per-channel synchronous return to StIdle; blocks that channel's grant
//   out_valid     registered strobe, one per accepted bit
//   out_ch        channel of the registered result; holds between results
//   out_detected  the accepted bit completed 10110 on out_ch
//   stat_sel      (SEQ_ARB_STATS_EN) selects the detect counter to read
//   stat_count    (SEQ_ARB_STATS_EN) selected 16-bit saturating detect count
//
// Build option: define SEQ_ARB_STATS_EN to add the per-channel detect
// counters and the stat_sel/stat_count ports.
//
// state     | meaning
// ----------+-------------------------------------------
// StIdle    | no useful prefix seen
// St1       | "1" seen
// St10      | "10" seen
// St101     | "101" seen
// St1011    | "1011" seen; a 0 completes the pattern
// St10110   | pattern just completed; "10" suffix kept for overlap

module seq_detect_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
`ifdef SEQ_ARB_STATS_EN
    input  logic [CH_W-1:0]   stat_sel,
    output logic [15:0]       stat_count,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_bit,
    output logic [NUM_CH-1:0] req_ready,
    input  logic [NUM_CH-1:0] ctx_clear,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_detected
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        St1      = 3'd1,
        St10     = 3'd2,
        St101    = 3'd3,
        St1011   = 3'd4,
        St10110  = 3'd5
    } state_t;

    state_t              ctx [NUM_CH];
    logic [CH_W-1:0]     rr_ptr;

    logic [NUM_CH-1:0]   eligible;
    logic                grant;
    logic [CH_W-1:0]     grant_idx;
    state_t              cur_state;
    state_t              nxt_state;
    logic                bit_in;
    logic                det;

    // Round-robin search upward from rr_ptr. A channel being cleared
    // cannot be granted, so a clear never collides with an update.
    always_comb begin
        eligible  = req_valid & ~ctx_clear;
        grant     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant && eligible[(int'(rr_ptr) + i) % NUM_CH]) begin
                grant     = 1'b1;
                grant_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
        req_ready = '0;
        if (grant && !reset)
            req_ready[grant_idx] = 1'b1;
    end

    // The single shared next-state function, applied to the granted channel's context.
    always_comb begin
        cur_state = ctx[grant_idx];
        bit_in    = req_bit[grant_idx];
        nxt_state = cur_state;
        det       = 1'b0;
        case (cur_state)
            StIdle:  nxt_state = bit_in ? St1    : StIdle;
            St1:     nxt_state = bit_in ? St1    : St10;
            St10:    nxt_state = bit_in ? St101  : StIdle;
            St101:   nxt_state = bit_in ? St1011 : St10;
            St1011: begin
                nxt_state = bit_in ? St1 : St10110;
                det       = ~bit_in;
            end
            St10110: nxt_state = bit_in ? St101  : StIdle;
            default: nxt_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                ctx[i] <= StIdle;
            rr_ptr       <= '0;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out_detected <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctx_clear[i])
                    ctx[i] <= StIdle;
                else if (grant && grant_idx == CH_W'(i))
                    ctx[i] <= nxt_state;
            end
            if (grant) begin
                rr_ptr <= CH_W'((int'(grant_idx) + 1) % NUM_CH);
                out_ch <= grant_idx;
            end
            out_valid    <= grant;
            out_detected <= grant & det;
        end
    end

`ifdef SEQ_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_CH];

    // Counts advance on the same edge that registers the detect result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctx_clear[i])
                    stat_cnt[i] <= '0;
                else if (grant && det && grant_idx == CH_W'(i) && stat_cnt[i] != 16'hFFFF)
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
            end
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter (NUM_CH = 4).
module tb_seq_detect_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_bit;
    logic [3:0] req_ready;
    logic [3:0] ctx_clear;
    logic       out_valid;
    logic [1:0] out_ch;
    logic       out_detected;
`ifdef SEQ_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    seq_detect_arbiter #(.NUM_CH(4)) dut (
`ifdef SEQ_ARB_STATS_EN
        .stat_sel     (stat_sel),
        .stat_count   (stat_count),
`endif
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_bit      (req_bit),
        .req_ready    (req_ready),
        .ctx_clear    (ctx_clear),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_detected (out_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] clear;
        logic [3:0] ready;
        logic       ov;
        logic [1:0] ch;
        logic       det;
        logic       pre_rst;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] valid, logic [3:0] bits, logic [3:0] clear,
                                logic [3:0] ready, logic ov, logic [1:0] ch, logic det,
                                logic pre_rst);
        vec_t v;
        v.valid = valid; v.bits = bits; v.clear = clear; v.ready = ready;
        v.ov = ov; v.ch = ch; v.det = det; v.pre_rst = pre_rst;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " ready"},  32'(req_ready),    32'h0);
        check({tag, " ov"},     32'(out_valid),    32'h0);
        check({tag, " ch"},     32'(out_ch),       32'h0);
        check({tag, " det"},    32'(out_detected), 32'h0);
    endtask

    task automatic do_reset();
        req_valid = 4'h0; req_bit = 4'h0; ctx_clear = 4'h0;
        reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one vector, check the combinational grant, then check the
    // registered result after the next rising edge.
    task automatic apply(vec_t v, string tag);
        req_valid = v.valid; req_bit = v.bits; ctx_clear = v.clear;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(v.ready));
        @(posedge clk);
        #1;
        check({tag, " ov"},  32'(out_valid),    32'(v.ov));
        check({tag, " ch"},  32'(out_ch),       32'(v.ch));
        check({tag, " det"}, 32'(out_detected), 32'(v.det));
    endtask

    initial begin
        logic [4:0] pat;
        logic [2:0] tail;

        // Single channel 10110, then overlap 110 x4.
        pat = 5'b10110;
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(4'b0001, {3'b0, pat[4-i]}, 4'b0, 4'b0001, 1'b1, 2'd0,
                            (i == 4), (i == 0)));
        tail = 3'b110;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 3; i++)
                tv.push_back(mk(4'b0001, {3'b0, tail[2-i]}, 4'b0, 4'b0001, 1'b1, 2'd0,
                                (i == 2), 1'b0));

        // Interleave: ch0 10110, ch1 00000; ch0 holds its pending bit when not granted.
        begin
            logic b0;
            int   k0;
            k0 = 0;
            for (int c = 0; c < 10; c++) begin
                b0 = pat[4-k0];
                if (c % 2 == 0) begin
                    tv.push_back(mk(4'b0011, {3'b0, b0}, 4'b0, 4'b0001, 1'b1, 2'd0,
                                    (k0 == 4), (c == 0)));
                    k0++;
                end else begin
                    tv.push_back(mk(4'b0011, {3'b0, b0}, 4'b0, 4'b0010, 1'b1, 2'd1,
                                    1'b0, 1'b0));
                end
            end
        end

        // Fairness: all four valid for 8 cycles, then only ch2/ch3.
        for (int c = 0; c < 8; c++)
            tv.push_back(mk(4'b1111, 4'b0, 4'b0, 4'(1 << (c % 4)), 1'b1, 2'(c % 4),
                            1'b0, (c == 0)));
        for (int c = 0; c < 4; c++)
            tv.push_back(mk(4'b1100, 4'b0, 4'b0, (c % 2 == 0) ? 4'b0100 : 4'b1000, 1'b1,
                            (c % 2 == 0) ? 2'd2 : 2'd3, 1'b0, 1'b0));

        // Clear on ch2 after 1011: following 0 must not detect; fresh 10110 must.
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(4'b0100, {1'b0, pat[4-i], 2'b0}, 4'b0, 4'b0100, 1'b1, 2'd2,
                            1'b0, (i == 0)));
        tv.push_back(mk(4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0));
        tv.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(4'b0100, {1'b0, pat[4-i], 2'b0}, 4'b0, 4'b0100, 1'b1, 2'd2,
                            (i == 4), 1'b0));

        // Reset state with requests pending.
        req_valid = 4'hF; req_bit = 4'hF; ctx_clear = 4'h0;
        reset = 1'b1;
        #3;
        check_reset_outputs("initial");
        @(negedge clk);
        reset = 1'b0;

        foreach (tv[k]) begin
            if (tv[k].pre_rst)
                do_reset();
            apply(tv[k], $sformatf("vec%0d", k));
        end

        // Reset mid-stream on ch1 after 1011: the next 0 must not detect.
        do_reset();
        for (int i = 0; i < 4; i++)
            apply(mk(4'b0010, {2'b0, pat[4-i], 1'b0}, 4'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0),
                  $sformatf("midrst%0d", i));
        req_bit = 4'b0000;
        reset = 1'b1;
        #2;
        check_reset_outputs("midrst_during");
        @(negedge clk);
        reset = 1'b0;
        apply(mk(4'b0010, 4'b0000, 4'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0), "midrst_after");

`ifdef SEQ_ARB_STATS_EN
        begin
            logic [10:0] sp;
            sp = 11'b10110110110;
            stat_sel = 2'd3;
            do_reset();
            for (int i = 0; i < 11; i++)
                apply(mk(4'b1000, {sp[10-i], 3'b0}, 4'b0, 4'b1000, 1'b1, 2'd3,
                         (i == 4 || i == 7 || i == 10), 1'b0), $sformatf("stat%0d", i));
            check("stat_count3", 32'(stat_count), 32'd3);
            apply(mk(4'b0000, 4'b0, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0), "stat_clr");
            check("stat_count_clr", 32'(stat_count), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

`ifdef SEQ_ARB_STATS_EN
    initial stat_sel = 2'd3;
`endif

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Time-multiplexed controller that shares one 10110 overlapping-pattern detection engine among NUM_CH serial bit requesters. Each requester keeps its own detector context (FSM state), so interleaved streams are each evaluated as if they had a private SimpleSequenceDetector. A round-robin arbiter grants one bit per cycle, and one registered result per cycle is tagged with the channel it belongs to. The block sits between the per-lane bit sources and the detection-event consumers.

## Interface
- NUM_CH, default 4, number of requesters (2..16); CH_W = $clog2(NUM_CH) is derived.
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_CH  bit i offers req_bit[i] from requester i
- req_bit  in  NUM_CH  serial data bit per requester
- req_ready  out  NUM_CH  one-hot grant; bit consumed when req_valid[i] & req_ready[i] at a clk edge
- ctx_clear  in  NUM_CH  synchronous per-channel context reset to StIdle
- out_valid  out  1  registered result strobe, one per accepted bit
- out_ch  out  CH_W  channel of the result
- out_detected  out  1  1 when the accepted bit completed 10110 on that channel

## Operation
- Per-channel context: 3-bit state in {StIdle, St1, St10, St101, St1011, St10110}, all StIdle at reset.
- Transitions (bit 0 / bit 1): StIdle→StIdle/St1; St1→St10/St1; St10→StIdle/St101; St101→St10/St1011; St1011→St10110 (detect)/St1; St10110→StIdle/St101.
- Detect is asserted only for bit 0 accepted while in St1011. Overlap is supported: 10110110 detects twice.
- Arbitration: eligible[i] = req_valid[i] & ~ctx_clear[i]. Grant goes to the first eligible channel searching upward (with wrap) from rr_ptr. req_ready is combinational from eligible and rr_ptr, and at most one bit is set.
- When a grant occurs, rr_ptr ← granted+1 (mod NUM_CH). When nothing is eligible, rr_ptr holds. rr_ptr resets to 0.
- Accepted bit: the granted channel's context is updated with the shared next-state logic at the same edge, and the result is registered. Non-granted contexts hold.
- ctx_clear[i]: channel i's context is set to StIdle at the edge. ctx_clear takes priority over a pending bit on that channel, and that channel gets no ready that cycle.
- Engine is single-issue: exactly one context read/modify/write per cycle. No buffering; requesters hold valid until ready.

## Timing
- Reset values: req_ready=0 (while reset is high), out_valid=0, out_ch=0, out_detected=0, rr_ptr=0, all contexts StIdle.
- Latency: bit accepted at edge N → out_valid=1, out_ch, out_detected valid after edge N, sampled at edge N+1.
- out_valid=0 with out_detected=0 in every cycle after an edge with no acceptance. out_ch holds its last value.
- Throughput: 1 bit/cycle aggregate. A lone valid requester is granted every cycle. With k requesters valid, each gets 1 grant per k cycles.
- Back-to-back bits on the same channel use the updated context. There is no stale-state hazard.
- Reset mid-operation: all in-flight results are dropped and contexts return to StIdle. The first result after release reflects a fresh pattern.

## Configuration
- SEQ_ARB_STATS_EN defined: the block adds per-channel 16-bit saturating detection counters (cleared by reset and by ctx_clear[i], increment on a registered detect, hold at 0xFFFF). It also adds the ports stat_sel in CH_W and stat_count out 16 (combinational read of counter[stat_sel]).
- Undefined: no counters and no stat ports. All other behaviour is identical.

## Test plan
- Single channel: ch0 drives 1,0,1,1,0 back-to-back, others idle. Required: req_ready[0] every cycle; results out_ch=0 with out_detected 0,0,0,0,1.
- Overlap: ch0 continues with 1,1,0 (then repeat 1,1,0 ×3). Required: out_detected=1 on every third result; no other detects.
- Interleave: ch0 streams 10110 and ch1 streams 00000, both always valid. Required: grants alternate 0,1,0,1…; exactly one detect, with out_ch=0 on ch0's 5th result.
- Fairness: all 4 channels valid for 8 cycles from reset. Required: grant order 0,1,2,3,0,1,2,3. Then only ch2 and ch3 are valid: grants alternate 2,3 starting from rr_ptr.
- Clear and reset: ch2 sends 1,0,1,1, pulses ctx_clear[2] (ready[2]=0 that cycle), then sends 0 → no detect; 1,0,1,1,0 → detect. Reset is asserted mid-stream on ch1 after 1011, then 0 is sent → no detect. All outputs are 0 during reset.
- Stats (SEQ_ARB_STATS_EN): ch3 gets 3 detects, stat_sel=3 → stat_count=3. ctx_clear[3] → 0. 70000 forced detects → saturates at 65535.
